rr_dispatcher: RTL
==================

// Module: rr_dispatcher
// PURPOSE
//  1:N round-robin dispatcher: the distribution-side counterpart of the N:1 round-robin arbiter.
//  - One valid/ready input stream is spread across PORT output channels in rotating order.
//  - Each output channel holds a one-entry register slot.
//  - Feeds replicated workers (e.g. parallel compute lanes) whose results are later merged by rr_arbiter.
// PARAMETERS
//  PORT  4                          number of output channels (>=1; need not be a power of two)
//  DATA  32                         payload width in bits
//  IDX   (PORT>1)?$clog2(PORT):1    constant; pointer width, do not override
// PORTS
//  clk        in   1          single clock, all logic on posedge
//  reset_n    in   1          synchronous, active-low reset
//  in_valid   in   1          input payload valid
//  in_data    in   DATA       input payload
//  in_ready   out  1          input accepted when in_valid & in_ready
//  out_valid  out  PORT       per-channel slot valid (registered)
//  out_data   out  PORT*DATA  channel i payload at [i*DATA +: DATA] (registered)
//  out_ready  in   PORT       per-channel consumer ready
//  next_idx   out  IDX        current round-robin pointer r_next (registered)
// BEHAVIOUR
//  Reset (reset_n==0 at posedge):
//  - out_valid=0, out_data=0, r_next=0.
//  - in_ready is forced 0 combinationally while reset_n==0.
//  Slot free[i] = ~out_valid[i] | out_ready[i].
//  - A slot may be drained and refilled in the same cycle.
//  Output handshake:
//  - Slot i empties when out_valid[i] & out_ready[i], unless it is refilled that cycle.
//  - out_valid/out_data are held stable while out_valid[i] & ~out_ready[i].
//  Target select (combinational, see CONFIGURATION): target index tgt.
//  - in_ready = free[tgt] & reset_n.
//  Transfer (in_valid & in_ready at posedge):
//  - slot[tgt] <= in_data, out_valid[tgt] <= 1.
//  - r_next <= (tgt==PORT-1) ? 0 : tgt+1. Explicit wrap at PORT, not at 2**IDX.
//  - No transfer: r_next holds.
//  Latency: a word accepted at edge t is visible on out_valid/out_data from t+1. No combinational path from in_* to out_*.
//  Combinational paths: out_ready -> in_ready only. in_ready does not depend on in_valid.
//  Order: words go to channels in strictly increasing index modulo PORT, skipping channels only when DISPATCH_SKIP_EN is set.
//  Reset mid-stream: all buffered words are discarded (out_valid=0). Downstream must tolerate the loss.
//  PORT==1: tgt is always 0 and r_next stays 0. The block degenerates to a one-entry pipeline register.
// CONFIGURATION
//  Macro RR_DISPATCH_SKIP_EN selects the target policy.
//  - Undefined (strict round-robin): tgt = r_next.
//    - Input stalls while channel r_next is full, even if other channels are free.
//    - Gives deterministic channel assignment (word k -> channel k mod PORT).
//  - Defined (work-conserving):
//    - tgt = first i scanning r_next, r_next+1, ..., wrapping through PORT-1 to 0, with free[i]=1.
//    - in_ready = |free & reset_n.
//    - If no slot is free, tgt = r_next (don't-care) and in_ready = 0.
// TESTING
//  T1 reset: hold reset_n=0 with in_valid=1 -> in_ready=0, out_valid=0, next_idx=0. Release -> in_ready=1.
//  T2 rotation: PORT=4, out_ready=4'hF, in_valid=1, data 0xA0..0xA5 on consecutive cycles
//     -> channels 0,1,2,3,0,1 each receive one word, 1 cycle later; next_idx after the 6th word = 2.
//  T3 backpressure: out_ready=4'b0000, send 5 words.
//     -> 4 words accepted (one per channel). in_ready=0 on the 5th, which is held.
//     -> Raise out_ready[0]: the 5th word enters channel 0 the same cycle that channel 0 drains.
//  T4 policy: fill ch1 with out_ready[1]=0, r_next=1, in_valid=1.
//     -> Without RR_DISPATCH_SKIP_EN: in_ready=0.
//     -> With it: the word goes to ch2 and next_idx becomes 3.
//  T5 wrap, PORT=3: 7 words with out_ready all 1 -> channels 0,1,2,0,1,2,0; next_idx never reaches 3.
//  T6 mid-stream reset: 3 slots valid, pulse reset_n=0 for one cycle
//     -> out_valid=0 and next_idx=0 next cycle; the next word goes to channel 0.
//  Checks: scoreboard payload order per channel; assert out_data stable while valid & ~ready.

Source files
------------

// File: rtl/rr_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_dispatcher                                                 |
// | Brief    : 1:N round-robin dispatcher. Spreads one valid/ready input     |
// |            stream across PORT output channels in rotating order. Each    |
// |            channel owns a one-entry register slot.                       |
// | Options  : RR_DISPATCH_SKIP_EN - when defined, the target is the first   |
// |            free slot scanning from r_next (work-conserving). When        |
// |            undefined, the target is always r_next (strict round-robin).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module rr_dispatcher #(
  parameter int PORT = 4,
  parameter int DATA = 32,
  parameter int IDX  = (PORT > 1) ? $clog2(PORT) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA-1:0]      in_data,
  output logic                 in_ready,
  output logic [PORT-1:0]      out_valid,
  output logic [PORT*DATA-1:0] out_data,
  input  logic [PORT-1:0]      out_ready,
  output logic [IDX-1:0]       next_idx
);

  // Channel slot storage and round-robin pointer
  logic [PORT-1:0] r_valid;
  logic [DATA-1:0] r_data [PORT];
  logic [IDX-1:0]  r_next;

  // Slot can take a word this cycle: empty, or being drained right now
  logic [PORT-1:0] w_free;
  logic [IDX-1:0]  w_tgt;
  logic            w_tgt_free;
  logic            w_accept;
  logic [IDX-1:0]  w_next_ptr;

  assign w_free = ~r_valid | out_ready;

`ifdef RR_DISPATCH_SKIP_EN
  // Add an offset to the pointer with an explicit wrap at PORT (PORT need not be 2**IDX)
  function automatic logic [IDX-1:0] wrap_add(input logic [IDX-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= PORT) begin
      s = s - PORT;
    end
    return s[IDX-1:0];
  endfunction

  // Work-conserving select: first free slot at or after r_next, wrapping around
  always_comb begin
    w_tgt      = r_next;
    w_tgt_free = 1'b0;
    for (int k = 0; k < PORT; k++) begin
      if (!w_tgt_free && w_free[wrap_add(r_next, k)]) begin
        w_tgt      = wrap_add(r_next, k);
        w_tgt_free = 1'b1;
      end
    end
  end
`else
  // Strict select: always the pointed-to channel, stalling if it is full
  always_comb begin
    w_tgt      = r_next;
    w_tgt_free = w_free[r_next];
  end
`endif

  // Ready never depends on in_valid; it is held low during reset
  assign in_ready = w_tgt_free & reset_n;
  assign w_accept = in_valid & in_ready;

  // Pointer after the target, wrapping at PORT-1 rather than at 2**IDX
  assign w_next_ptr = (w_tgt == IDX'(PORT - 1)) ? '0 : w_tgt + IDX'(1);

  // Round-robin pointer advances only on an accepted word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_next <= '0;
    end else if (w_accept) begin
      r_next <= w_next_ptr;
    end
  end

  generate
    for (genvar i = 0; i < PORT; i++) begin : g_slot
      // One-entry slot: refill wins over drain; contents held while stalled
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_valid[i] <= 1'b0;
          r_data[i]  <= '0;
        end else if (w_accept && (w_tgt == IDX'(i))) begin
          r_valid[i] <= 1'b1;
          r_data[i]  <= in_data;
        end else if (out_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end

      assign out_data[i*DATA +: DATA] = r_data[i];
    end
  endgenerate

  assign out_valid = r_valid;
  assign next_idx  = r_next;

endmodule
`default_nettype wire
